// File: rtl/bit_scan_encoder.sv
// -----------------------------------------------------------------------------
// bit_scan_encoder
//
// Accepts a WIDTH-bit request vector and emits the index of every set bit, one
// per beat, in priority order (lowest index first, or highest first when
// MSB_FIRST=1). With a one-hot vector this degenerates to a plain binary
// encoder. An all-zero vector is swallowed and reported by a one-cycle
// zero_flag pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   in_vec is offered (ignored while scanning)
//   in_ready   block is idle and can accept a new vector
//   in_vec     request vector
//   out_valid  out_idx holds a valid index
//   out_ready  downstream consumes the current index
//   out_idx    index of the current highest-priority pending bit (0 when idle)
//   out_last   current index is the final pending bit
//   pending    popcount of the pending mask, including the current bit
//   zero_flag  one-cycle pulse after an all-zero vector is accepted
// -----------------------------------------------------------------------------
module bit_scan_encoder #(
  parameter  int WIDTH     = 16,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   pending,
  output logic             zero_flag
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               zero_q, zero_d;

  // Everything on the output side is derived from mask_q only, so there is no
  // combinational path from in_vec to out_idx / out_last / pending.
  logic [IDX_W-1:0]   scan_idx;
  logic [CNT_W-1:0]   scan_cnt;
  logic               scan_last;

  // ---------------------------------------------------------------------------
  // Priority encoder over the pending mask. The loop runs towards the winning
  // end so the last match assigned is the one with highest priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinationally written signal gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    scan_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mask_q[i]) scan_idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask_q[i]) scan_idx = IDX_W'(i);
      end
    end
  end

  // Popcount of the pending mask.
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      scan_cnt = scan_cnt + CNT_W'(mask_q[i]);
    end
  end

  assign scan_last = (scan_cnt == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // State register (also holds the mask and the zero-vector pulse).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      zero_q  <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|in_vec) begin
            mask_d  = in_vec;
            state_d = SCAN;
          end else begin
            zero_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        // in_valid / in_vec are deliberately not looked at here.
        if (out_ready) begin
          mask_d[scan_idx] = 1'b0;
          if (scan_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. The mask is zero whenever the block is idle, but the outputs
  // are still qualified by state so idle values never depend on mask contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SCAN);
    out_idx   = '0;
    out_last  = 1'b0;
    pending   = '0;
    if (state_q == SCAN) begin
      out_idx  = scan_idx;
      out_last = scan_last;
      pending  = scan_cnt;
    end
    zero_flag = zero_q;
  end

endmodule

// File: doc/bit_scan_encoder.md
BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, giving the number of request bits (power of two, 4..64).
REQ-002 The block SHALL expose parameter MSB_FIRST, default 0, which selects scan order: 0 means lowest index first, 1 means highest index first.
REQ-003 The block SHALL derive local parameter IDX_W = log2(WIDTH), which is 4 at the default.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous reset, active-high.
REQ-007 Port: in_valid  input  1  in_vec is offered.
REQ-008 Port: in_ready  output  1  block can accept a new vector.
REQ-009 Port: in_vec  input  WIDTH  request vector; each set bit is one index to emit.
REQ-010 Port: out_valid  output  1  out_idx holds a valid encoded index.
REQ-011 Port: out_ready  input  1  downstream consumes the current index.
REQ-012 Port: out_idx  output  IDX_W  binary index of the current highest-priority pending bit.
REQ-013 Port: out_last  output  1  the current index is the final pending bit of the vector.
REQ-014 Port: pending  output  IDX_W+1  popcount of the pending mask, including the current bit.
REQ-015 Port: zero_flag  output  1  one-cycle pulse when an all-zero vector is accepted.

Function
REQ-016 The block SHALL implement two states, IDLE and SCAN, held in a registered state variable.
REQ-017 In IDLE the block SHALL drive in_ready=1, out_valid=0 and pending=0; in SCAN it SHALL drive in_ready=0 and out_valid=1.
REQ-018 Accept: when in IDLE with in_valid=1 and in_vec!=0, the block SHALL load in_vec into the mask register and enter SCAN at that edge; out_valid SHALL rise in the next cycle (latency 1).
REQ-019 When in IDLE with in_valid=1 and in_vec==0, the block SHALL remain in IDLE and assert zero_flag for exactly the following cycle.
REQ-020 In SCAN, out_idx SHALL be the index of the lowest set mask bit when MSB_FIRST=0, or the highest set mask bit when MSB_FIRST=1.
REQ-021 out_last SHALL be 1 exactly when pending==1.
REQ-022 Beat transfer occurs on an edge where out_valid=1 and out_ready=1; at that edge the block SHALL clear the mask bit at out_idx.
REQ-023 On a transfer with out_last=1, the block SHALL return to IDLE at that edge; in_ready SHALL be 1 in the next cycle, so back-to-back vectors are separated by one idle cycle.
REQ-024 With out_valid=1 and out_ready=0, out_idx, out_last, pending and the mask SHALL hold unchanged.
REQ-025 in_vec and in_valid SHALL be ignored while in SCAN.
REQ-026 out_idx, out_last and pending SHALL be pure functions of the registered mask, with no combinational path from in_vec.
REQ-027 out_idx SHALL read 0 whenever out_valid=0.
REQ-028 For a one-hot in_vec, the single emitted index SHALL equal the index of the set bit, so that behaviour matches a plain WIDTH-to-IDX_W encoder.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set state=IDLE, mask=0 and zero_flag=0; rst SHALL take priority over any simultaneous accept or transfer.
REQ-030 In the first cycle after reset, outputs SHALL be in_ready=1, out_valid=0, out_idx=0, out_last=0, pending=0 and zero_flag=0.
REQ-031 A reset asserted mid-scan SHALL discard all remaining pending bits, and no further out_valid beats SHALL appear.

Verification
REQ-032 Walking one, with in_vec set to 16'h0001 through 16'h8000 in turn and out_ready=1: each vector SHALL produce one beat with out_idx 0..15 respectively and out_last=1.
REQ-033 Multi-bit vector 16'h8421 with out_ready=1: MSB_FIRST=0 SHALL give out_idx 0,5,10,15 with pending 4,3,2,1 and out_last only on 15; MSB_FIRST=1 SHALL give 15,10,5,0.
REQ-034 Backpressure, with 16'h0030 and out_ready=0 held for 3 cycles: out_idx=4 and pending=2 SHALL hold stable, then the sequence SHALL continue 4, then 5 (last).
REQ-035 Zero vector, with in_vec=16'h0000 and in_valid=1: zero_flag SHALL be high for one cycle, out_valid SHALL stay 0 and in_ready SHALL stay 1.
REQ-036 Full vector 16'hFFFF: there SHALL be 16 beats, with pending counting 16 down to 1 and the last beat at index 15 (MSB_FIRST=0).
REQ-037 Reset mid-scan, with rst pulsed after the 2nd beat of 16'hFFFF: the next cycle SHALL show out_valid=0, pending=0 and in_ready=1, and a subsequent 16'h0002 SHALL yield the single index 1.
